// File: rtl/neuron_mac_pkg.sv
// Shared definitions for the neuron MAC: saturation limits, FSM encoding and
// width-generic saturating arithmetic helpers.
package neuron_mac_pkg;

    localparam int DATA_WIDTH = 16;
    localparam logic signed [DATA_WIDTH-1:0] SAT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [DATA_WIDTH-1:0] SAT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        ACC   = 2'd0,
        DRAIN = 2'd1,
        BIAS  = 2'd2
    } state_t;

    // Clamp a sign-extended value into the signed range of a w-bit word (w < 64).
    function automatic logic signed [63:0] sat_clamp(input logic signed [63:0] v, input int w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (v > hi)
            return hi;
        else if (v < lo)
            return lo;
        else
            return v;
    endfunction

    function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                   input logic signed [63:0] b,
                                                   input int w);
        return sat_clamp(a + b, w);
    endfunction

endpackage

// File: rtl/neuron_mac_sat_mac_unit.sv
// Multiply register, fixed-point rescale and saturating accumulator for the
// neuron MAC. Carries a valid/last tag alongside the two pipeline stages.
module neuron_mac_sat_mac_unit
    import neuron_mac_pkg::*;
#(
    parameter int dataWidth = DATA_WIDTH,
    parameter int fracBits  = 12
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        acc_en,
    input  logic                        acc_last,
    input  logic signed [dataWidth-1:0] in_data,
    input  logic signed [dataWidth-1:0] wout,
    input  logic                        clr,
    output logic signed [dataWidth-1:0] acc,
    output logic                        last_done
);

    localparam int PW = 2 * dataWidth;

    logic signed [dataWidth-1:0] in_d_reg;
    logic                        v0_reg, l0_reg, v1_reg, l1_reg;
    logic signed [PW-1:0]        prod_reg;
    logic signed [PW-1:0]        shifted;
    logic signed [dataWidth-1:0] acc_reg, acc_next;

    // The rescaled product is clamped to the word before it meets the accumulator.
    always_comb begin
        shifted  = prod_reg >>> fracBits;
        acc_next = dataWidth'(sat_add(64'(acc_reg), sat_clamp(64'(shifted), dataWidth), dataWidth));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_d_reg <= '0;
            v0_reg   <= 1'b0;
            l0_reg   <= 1'b0;
            v1_reg   <= 1'b0;
            l1_reg   <= 1'b0;
            prod_reg <= '0;
            acc_reg  <= '0;
        end else begin
            v0_reg <= acc_en;
            l0_reg <= acc_en && acc_last;
            if (acc_en)
                in_d_reg <= in_data;
            v1_reg   <= v0_reg;
            l1_reg   <= l0_reg;
            prod_reg <= PW'(in_d_reg) * PW'(wout);
            if (clr)
                acc_reg <= '0;
            else if (v1_reg)
                acc_reg <= acc_next;
        end
    end

    assign acc       = acc_reg;
    assign last_done = v1_reg && l1_reg;

endmodule

// File: rtl/neuron_mac.sv
// Neuron MAC top: weight-address counter, input handshake and ACC/DRAIN/BIAS FSM.
// Build option NEURON_RELU_EN applies ReLU to the output.
module neuron_mac
    import neuron_mac_pkg::*;
#(
    parameter int dataWidth    = DATA_WIDTH,
    parameter int fracBits     = 12,
    parameter int addressWidth = 10,
    parameter int numWeight    = 784
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic signed [dataWidth-1:0] in_data,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic signed [dataWidth-1:0] bias,
    output logic                        ren,
    output logic [addressWidth:0]       raddr,
    input  logic signed [dataWidth-1:0] wout,
    output logic signed [dataWidth-1:0] out_data,
    output logic                        out_valid
);

    localparam int AW1 = addressWidth + 1;
    localparam logic [AW1-1:0] LAST_IDX = AW1'(numWeight - 1);

    state_t                      state_reg, state_next;
    logic [AW1-1:0]              cnt_reg, cnt_next;
    logic                        accept, is_last, fire, last_done;
    logic signed [dataWidth-1:0] acc;
    logic signed [dataWidth-1:0] sum_sat, result;
    logic signed [dataWidth-1:0] out_data_reg;
    logic                        out_valid_reg;

    assign in_ready = rst_n && (state_reg == ACC);
    assign accept   = in_valid && in_ready;
    assign ren      = accept;
    assign raddr    = cnt_reg;
    assign is_last  = (cnt_reg == LAST_IDX);

    neuron_mac_sat_mac_unit #(
        .dataWidth (dataWidth),
        .fracBits  (fracBits)
    ) u_mac (
        .clk       (clk),
        .rst_n     (rst_n),
        .acc_en    (accept),
        .acc_last  (is_last),
        .in_data   (in_data),
        .wout      (wout),
        .clr       (fire),
        .acc       (acc),
        .last_done (last_done)
    );

    always_comb begin
        sum_sat = dataWidth'(sat_add(64'(acc), 64'(bias), dataWidth));
`ifdef NEURON_RELU_EN
        result = sum_sat[dataWidth-1] ? '0 : sum_sat;
`else
        result = sum_sat;
`endif
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        fire       = 1'b0;
        case (state_reg)
            ACC: begin
                if (accept) begin
                    if (is_last) begin
                        cnt_next   = '0;
                        state_next = DRAIN;
                    end else begin
                        cnt_next = cnt_reg + AW1'(1);
                    end
                end
            end
            DRAIN: begin
                if (last_done)
                    state_next = BIAS;
            end
            BIAS: begin
                fire       = 1'b1;
                state_next = ACC;
            end
            default: state_next = ACC;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ACC;
            cnt_reg       <= '0;
            out_data_reg  <= '0;
            out_valid_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            out_valid_reg <= fire;
            if (fire)
                out_data_reg <= result;
        end
    end

    assign out_data  = out_data_reg;
    assign out_valid = out_valid_reg;

endmodule

// File: tb/tb_neuron_mac.sv
// Self-checking bench for neuron_mac with a weight-memory model and an
// arithmetic reference model of the saturating dot product.
module tb_neuron_mac;
    import neuron_mac_pkg::*;

    localparam int DW = 16;
    localparam int FB = 12;
    localparam int AW = 10;
    localparam int NW = 4;
`ifdef NEURON_RELU_EN
    localparam logic [DW-1:0] NEG_SAT_EXP = 16'h0000;
    localparam logic [DW-1:0] NEG_ONE_EXP = 16'h0000;
`else
    localparam logic [DW-1:0] NEG_SAT_EXP = 16'h8000;
    localparam logic [DW-1:0] NEG_ONE_EXP = 16'hC000;
`endif

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic signed [DW-1:0] in_data = '0;
    logic                 in_valid = 1'b0;
    logic signed [DW-1:0] bias = '0;
    logic signed [DW-1:0] wout = '0;
    logic                 in_ready, ren, out_valid;
    logic [AW:0]          raddr;
    logic signed [DW-1:0] out_data;

    neuron_mac #(
        .dataWidth    (DW),
        .fracBits     (FB),
        .addressWidth (AW),
        .numWeight    (NW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .bias      (bias),
        .ren       (ren),
        .raddr     (raddr),
        .wout      (wout),
        .out_data  (out_data),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] wmem [NW];
    logic [DW-1:0] vin  [NW];
    int            cyc = 0;
    int            last_acc = 0;
    int            ren_err = 0;
    int            pulses = 0;
    int            addr_q[$];
    int            total = 0;
    int            passed = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (ren)
            wout <= wmem[int'(raddr)];
    end

    always @(negedge clk) begin
        if (ren !== (in_valid && in_ready))
            ren_err = ren_err + 1;
        if (ren)
            addr_q.push_back(int'(raddr));
        if (out_valid)
            pulses = pulses + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic longint clamp(input longint v);
        longint hi = (longint'(1) <<< (DW - 1)) - 1;
        longint lo = -(longint'(1) <<< (DW - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    function automatic logic [DW-1:0] model(input logic [DW-1:0] b);
        longint acc = 0;
        longint p;
        for (int i = 0; i < NW; i++) begin
            p   = longint'($signed(vin[i])) * longint'($signed(wmem[i]));
            p   = clamp(p >>> FB);
            acc = clamp(acc + p);
        end
        acc = clamp(acc + longint'($signed(b)));
`ifdef NEURON_RELU_EN
        if (acc < 0) acc = 0;
`endif
        return acc[DW-1:0];
    endfunction

    task automatic send_sample(input logic [DW-1:0] d, input string tag);
        int budget = 0;
        in_valid = 1'b1;
        in_data  = d;
        while (!in_ready && budget < 50) begin
            @(negedge clk);
            budget++;
        end
        if (budget >= 50) chk({tag, "_ready_wait"}, 32'(budget), 0);
        @(posedge clk);
        #1 last_acc = cyc;
    endtask

    // Sends vin[] with `gap` idle cycles between samples, then waits for the pulse.
    task automatic do_vec(input string tag, input int gap, input logic [DW-1:0] b,
                          input bit use_const, input logic [DW-1:0] exp_const, input bit junk);
        int n = 0;
        int rdy_bad = 0;
        logic [DW-1:0] got = 'x;
        logic [DW-1:0] exp_m;
        bit rdy_pulse = 1'b0;
        bit seen = 1'b0;
        addr_q.delete();
        bias  = b;
        exp_m = model(b);
        for (int i = 0; i < NW; i++) begin
            @(negedge clk);
            if (i > 0 && gap > 0) begin
                in_valid = 1'b0;
                repeat (gap) @(negedge clk);
            end
            send_sample(vin[i], tag);
        end
        while (n < 20 && !seen) begin
            @(negedge clk);
            if (out_valid) begin
                seen      = 1'b1;
                got       = out_data;
                rdy_pulse = in_ready;
                in_valid  = 1'b0;
            end else begin
                if (in_ready) rdy_bad++;
                in_valid = junk;
                in_data  = 16'h7FFF;
                n++;
            end
        end
        $display("vec %s out_data=%h model=%h latency=%0d", tag, got, exp_m, cyc - last_acc);
        chk({tag, "_model"}, 32'(got), 32'(exp_m));
        if (use_const) chk({tag, "_const"}, 32'(got), 32'(exp_const));
        chk({tag, "_latency"}, 32'(cyc - last_acc), 3);
        chk({tag, "_ready_low"}, 32'(rdy_bad), 0);
        chk({tag, "_ready_at_pulse"}, 32'(rdy_pulse), 1);
        chk({tag, "_naddr"}, 32'(addr_q.size()), NW);
        for (int i = 0; i < addr_q.size() && i < NW; i++)
            chk({tag, "_raddr"}, 32'(addr_q[i]), 32'(i));
        @(negedge clk);
        chk({tag, "_pulse_width"}, 32'(out_valid), 0);
    endtask

    task automatic fill(input logic [DW-1:0] w, input logic [DW-1:0] x);
        for (int i = 0; i < NW; i++) begin
            wmem[i] = w;
            vin[i]  = x;
        end
    endtask

    initial begin
        int exp_pulses = 0;
        fill(16'h1000, 16'h0800);
        #12;
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_ren", 32'(ren), 0);
        chk("rst_raddr", 32'(raddr), 0);
        chk("rst_out_data", 32'(out_data), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("post_rst_in_ready", 32'(in_ready), 1);

        do_vec("basic", 0, 16'h0400, 1'b1, 16'h2400, 1'b0);
        exp_pulses++;
        do_vec("gapped", 2, 16'h0400, 1'b1, 16'h2400, 1'b0);
        exp_pulses++;

        fill(16'h7000, 16'h7000);
        do_vec("sat_pos", 0, 16'h0000, 1'b1, 16'h7FFF, 1'b0);
        exp_pulses++;
        fill(16'h7000, 16'h9000);
        do_vec("sat_neg", 0, 16'h0000, 1'b1, NEG_SAT_EXP, 1'b0);
        exp_pulses++;
        fill(16'h1000, 16'hF000);
        do_vec("neg_one", 0, 16'h0000, 1'b1, NEG_ONE_EXP, 1'b0);
        exp_pulses++;

        // Two accepts, then reset drops everything mid-vector.
        fill(16'h1000, 16'h0800);
        @(negedge clk);
        send_sample(vin[0], "mid");
        @(negedge clk);
        send_sample(vin[1], "mid");
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        chk("midrst_out_data", 32'(out_data), 0);
        chk("midrst_out_valid", 32'(out_valid), 0);
        chk("midrst_in_ready", 32'(in_ready), 0);
        chk("midrst_raddr", 32'(raddr), 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < NW; i++) begin
            wmem[i] = DW'($urandom_range(0, 8191));
            vin[i]  = DW'($urandom_range(0, 8191));
        end
        do_vec("after_rst", 0, 16'h0100, 1'b0, 16'h0000, 1'b0);
        exp_pulses++;

        // Junk offered during DRAIN/BIAS must be ignored; then a bias-only vector.
        fill(16'h1000, 16'h0800);
        do_vec("b2b_first", 0, 16'h0400, 1'b1, 16'h2400, 1'b1);
        exp_pulses++;
        fill(16'h1000, 16'h0000);
        do_vec("b2b_second", 0, 16'h0400, 1'b1, 16'h0400, 1'b0);
        exp_pulses++;

        for (int v = 0; v < 4; v++) begin
            for (int i = 0; i < NW; i++) begin
                wmem[i] = DW'($urandom);
                vin[i]  = (v % 2 == 0) ? DW'($urandom) : DW'($urandom_range(0, 8191) - 4096);
            end
            do_vec("random", v % 2, DW'($urandom), 1'b0, 16'h0000, 1'b0);
            exp_pulses++;
        end

        chk("ren_equals_accept", 32'(ren_err), 0);
        chk("pulse_count", 32'(pulses), 32'(exp_pulses));
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=%0d expected_cycles_below=%0d", cyc, 20000);
        $fatal(1, "timeout");
    end

endmodule
